pipe_add_sub: RTL



---
 rtl/add_pkg.sv | 37 +++
 rtl/add_chunk.sv | 20 ++
 rtl/full_adder.sv | 11 +
 rtl/pipe_add_sub.sv | 115 +++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Chunking helpers and the stage payload shared by the pipelined adder/subtractor.
package add_pkg;

  // Widest operand the payload struct can carry.
  localparam int MAX_W = 128;

  function automatic int chunk_sz(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  function automatic int chunk_lo(input int width, input int stages, input int k);
    return k * chunk_sz(width, stages);
  endfunction

  // Width of chunk k; the last chunk takes the remainder and may be empty.
  function automatic int chunk_w(input int width, input int stages, input int k);
    int lo;
    int c;
    lo = chunk_lo(width, stages, k);
    c  = chunk_sz(width, stages);
    if (lo >= width) return 0;
    return (width - lo < c) ? width - lo : c;
  endfunction

  function automatic int last_chunk_w(input int width, input int stages);
    return chunk_w(width, stages, stages - 1);
  endfunction

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [MAX_W-1:0] s;
    logic [MAX_W-1:0] a;
    logic [MAX_W-1:0] b;
  } stage_t;

endpackage

// File: rtl/add_chunk.sv
// Combinational W-bit ripple adder built from full_adder cells.
module add_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end

  assign cout = c[W];
endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor, one carry-chain chunk per stage, valid/ready.
// Define ADD_FLAGS_EN to add registered zero and signed-overflow outputs.
module pipe_add_sub
  import add_pkg::*;
#(
  parameter int WIDTH  = 24,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADD_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);
  localparam int CHUNK = chunk_sz(WIDTH, STAGES);

  stage_t p_in;
  stage_t q [STAGES];
  stage_t d [STAGES];
  logic   stall;
  logic   unused_bits;

  assign out_valid = q[STAGES-1].valid;
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

  // Subtraction is A + ~B + 1; cin then toggles the extra increment.
  always_comb begin
    p_in                = '0;
    p_in.valid          = in_valid & in_ready;
    p_in.carry          = cin ^ sub;
    p_in.a[WIDTH-1:0]   = a;
    p_in.b[WIDTH-1:0]   = b ^ {WIDTH{sub}};
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    localparam int CW = chunk_w(WIDTH, STAGES, k);

    stage_t src;

    if (k == 0) begin : g_first
      assign src = p_in;
    end else begin : g_next
      assign src = q[k-1];
    end

    if (CW > 0) begin : g_add
      logic [CW-1:0] cs;
      logic          cc;
      stage_t        nxt;

      add_chunk #(.W(CW)) u_chunk (
        .a(src.a[LO +: CW]), .b(src.b[LO +: CW]), .cin(src.carry), .s(cs), .cout(cc)
      );

      always_comb begin
        nxt             = src;
        nxt.s[LO +: CW] = cs;
        nxt.carry       = cc;
      end
      assign d[k] = nxt;
    end else begin : g_pass
      assign d[k] = src;
    end
  end

  // Whole pipe advances together or holds together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) q[k] <= '0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) q[k] <= d[k];
    end
  end

  assign sum  = q[STAGES-1].s[WIDTH-1:0];
  assign cout = q[STAGES-1].carry;

  // Pending-operand and above-WIDTH bits of the final stage have no consumer.
  assign unused_bits = ^{q[STAGES-1].a, q[STAGES-1].b, q[STAGES-1].s};

`ifdef ADD_FLAGS_EN
  logic zero_d;
  logic ovf_d;

  // Carry into the MSB is recovered as a^b'^s at that bit.
  assign zero_d = (d[STAGES-1].s[WIDTH-1:0] == '0);
  assign ovf_d  = d[STAGES-1].a[WIDTH-1] ^ d[STAGES-1].b[WIDTH-1]
                ^ d[STAGES-1].s[WIDTH-1] ^ d[STAGES-1].carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else if (!stall) begin
      zero <= zero_d;
      ovf  <= ovf_d;
    end
  end
`endif

endmodule
